// File: rtl/barker_spreader_tx.sv
// 802.11b transmit chip sequencer: spreads each accepted data bit into
// CHIPS_PER_SYMBOL Barker chips, one chip per chip_strobe_in, via a one-entry hold buffer.
module barker_spreader_tx #(
    parameter int CHIPS_PER_SYMBOL = 11,
    parameter logic [CHIPS_PER_SYMBOL-1:0] BARKER = 11'b10110111000,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chip_strobe_in,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             chip_out,
    output logic             chip_valid,
    output logic             symbol_done,
    output logic             underrun,
    output logic             busy,
    output logic [IDX_W-1:0] chip_idx
);

    localparam int N     = CHIPS_PER_SYMBOL;
    localparam int LUT_W = 1 << IDX_W;

    // Chip k of the code sits at LUT bit k so the chip index addresses it directly.
    function automatic logic [LUT_W-1:0] build_lut();
        logic [LUT_W-1:0] lut;
        lut = '0;
        for (int i = 0; i < N; i++) begin
            lut[i] = BARKER[N-1-i];
        end
        return lut;
    endfunction

    localparam logic [LUT_W-1:0] CODE_LUT = build_lut();
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic {
        IDLE   = 1'b0,
        SPREAD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             hold_full;
    logic             hold_bit;
    logic             cur_bit;
    logic             accept;
    logic             consume;
    logic             chip_p0;
    logic             vld_p0;
    logic             last_p0;
    logic             underrun_p0;

    assign accept = bit_valid && !hold_full;

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            hold_full   <= 1'b0;
            chip_out    <= 1'b0;
            chip_valid  <= 1'b0;
            symbol_done <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            chip_valid  <= vld_p0;
            symbol_done <= last_p0;
            underrun    <= underrun_p0;
            if (vld_p0) begin
                chip_out <= chip_p0;
            end
            if (consume) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
            end
        end
    end

    // Data bits carry no reset: hold_full and the state machine decide when they matter.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_bit <= bit_in;
        end
        if (consume) begin
            cur_bit <= hold_bit;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        consume     = 1'b0;
        chip_p0     = 1'b0;
        vld_p0      = 1'b0;
        last_p0     = 1'b0;
        underrun_p0 = 1'b0;
        if (chip_strobe_in) begin
            if (idx == '0) begin
                if (hold_full) begin
                    consume    = 1'b1;
                    vld_p0     = 1'b1;
                    chip_p0    = CODE_LUT[0] ^ hold_bit;
                    idx_next   = ONE_IDX;
                    state_next = SPREAD;
                end else if (state == SPREAD) begin
                    // Symbol boundary reached with nothing queued: the stream broke.
                    underrun_p0 = 1'b1;
                    state_next  = IDLE;
                end
            end else if (idx == LAST_IDX) begin
                vld_p0   = 1'b1;
                chip_p0  = CODE_LUT[idx] ^ cur_bit;
                last_p0  = 1'b1;
                idx_next = '0;
            end else begin
                vld_p0   = 1'b1;
                chip_p0  = CODE_LUT[idx] ^ cur_bit;
                idx_next = idx + 1'b1;
            end
        end
    end

    always_comb begin
        bit_ready = !hold_full;
        busy      = (state == SPREAD);
        chip_idx  = idx;
    end

endmodule

// File: tb/tb_barker_spreader_tx.sv
// Directed bench for barker_spreader_tx: per-cycle comparison against a queue-based
// symbol model, plus literal chip sequences for the directed scenarios.
module tb_barker_spreader_tx;

    localparam int N = 11;
    localparam logic [10:0] BARKER_M = 11'b10110111000;
    localparam logic [10:0] LIT0 = 11'b10110111000;
    localparam logic [10:0] LIT1 = 11'b01001000111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chip_strobe_in = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic       chip_out;
    logic       chip_valid;
    logic       symbol_done;
    logic       underrun;
    logic       busy;
    logic [3:0] chip_idx;

    barker_spreader_tx #(
        .CHIPS_PER_SYMBOL(11),
        .BARKER(11'b10110111000),
        .IDX_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chip_strobe_in(chip_strobe_in),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .chip_out(chip_out),
        .chip_valid(chip_valid),
        .symbol_done(symbol_done),
        .underrun(underrun),
        .busy(busy),
        .chip_idx(chip_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: symbols are whole bits queued then played out chip by chip.
    bit   hold_q[$];
    bit   m_ok = 1'b0;
    bit   m_cur = 1'b0;
    bit   m_spread = 1'b0;
    bit   m_acc;
    int   m_next = 0;
    bit   e_chip = 1'b0;
    bit   e_cv = 1'b0;
    bit   e_sd = 1'b0;
    bit   e_ur = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1'b1;
            hold_q.delete();
            m_next = 0;
            m_spread = 1'b0;
            e_chip = 1'b0;
            e_cv = 1'b0;
            e_sd = 1'b0;
            e_ur = 1'b0;
        end else if (m_ok) begin
            m_acc = bit_valid && (hold_q.size() == 0);
            e_cv = 1'b0;
            e_sd = 1'b0;
            e_ur = 1'b0;
            if (chip_strobe_in) begin
                if (m_next == 0 && hold_q.size() == 0) begin
                    if (m_spread) e_ur = 1'b1;
                    m_spread = 1'b0;
                end else begin
                    if (m_next == 0) begin
                        m_cur = hold_q.pop_front();
                        m_spread = 1'b1;
                    end
                    e_chip = BARKER_M[N-1-m_next] ^ m_cur;
                    e_cv = 1'b1;
                    e_sd = (m_next == N - 1);
                    m_next = (m_next + 1) % N;
                end
            end
            if (m_acc) hold_q.push_back(bit_in);
        end
    end

    bit got[$];
    int sd_cnt = 0;
    int ur_cnt = 0;

    always @(negedge clk) begin
        if (m_ok) begin
            check("chip_valid", int'(chip_valid), int'(e_cv));
            check("chip_out", int'(chip_out), int'(e_chip));
            check("symbol_done", int'(symbol_done), int'(e_sd));
            check("underrun", int'(underrun), int'(e_ur));
            check("busy", int'(busy), int'(m_spread));
            check("bit_ready", int'(bit_ready), int'(hold_q.size() == 0));
            check("chip_idx", int'(chip_idx), m_next);
            if (chip_valid) got.push_back(chip_out);
            if (symbol_done) sd_cnt++;
            if (underrun) ur_cnt++;
        end
    end

    bit exp_q[$];

    task automatic push_lit(input logic [10:0] lit);
        for (int i = 10; i >= 0; i--) exp_q.push_back(lit[i]);
    endtask

    task automatic check_chips(input string name);
        check({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s_chip%0d", name, i), int'(got[i]), int'(exp_q[i]));
        end
    endtask

    task automatic clear_obs();
        got.delete();
        exp_q.delete();
        sd_cnt = 0;
        ur_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input bit b);
        int t;
        t = 0;
        while (!bit_ready && t < 200) begin
            step();
            t++;
        end
        check("bit_ready_wait", int'(bit_ready), 1);
        bit_in = b;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic strobes(input int n);
        for (int k = 0; k < n; k++) begin
            chip_strobe_in = 1'b1;
            step();
            chip_strobe_in = 1'b0;
            repeat (3) step();
        end
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within bound");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("reset_bit_ready", int'(bit_ready), 1);
        check("reset_chip_idx", int'(chip_idx), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_chip_valid", int'(chip_valid), 0);
        reset = 1'b0;
        step();

        // Single symbol, bit 0
        clear_obs();
        send_bit(1'b0);
        strobes(11);
        push_lit(LIT0);
        check_chips("t1");
        check("t1_symbol_done", sd_cnt, 1);
        check("t1_busy", int'(busy), 1);

        // Single symbol, bit 1
        clear_obs();
        send_bit(1'b1);
        strobes(11);
        push_lit(LIT1);
        check_chips("t2");
        check("t2_symbol_done", sd_cnt, 1);

        // Three back-to-back symbols
        clear_obs();
        send_bit(1'b0);
        fork
            strobes(33);
            begin
                send_bit(1'b1);
                send_bit(1'b0);
            end
        join
        push_lit(LIT0);
        push_lit(LIT1);
        push_lit(LIT0);
        check_chips("t3");
        check("t3_symbol_done", sd_cnt, 3);
        check("t3_underrun", ur_cnt, 0);

        // Underrun after a lone symbol, then a strobe while idle
        clear_obs();
        send_bit(1'b1);
        strobes(12);
        push_lit(LIT1);
        check_chips("t4");
        check("t4_underrun", ur_cnt, 1);
        check("t4_busy", int'(busy), 0);
        strobes(1);
        check("t4_idle_underrun", ur_cnt, 1);
        check("t4_idle_chips", got.size(), 11);

        // Reset in the middle of a symbol
        clear_obs();
        send_bit(1'b0);
        strobes(5);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("t5_chip_idx", int'(chip_idx), 0);
        check("t5_bit_ready", int'(bit_ready), 1);
        check("t5_busy", int'(busy), 0);
        check("t5_symbol_done", sd_cnt, 0);
        clear_obs();
        send_bit(1'b1);
        strobes(11);
        push_lit(LIT1);
        check_chips("t5");

        // Pending bit held off while the hold buffer is full
        clear_obs();
        send_bit(1'b0);
        bit_in = 1'b1;
        bit_valid = 1'b1;
        repeat (3) step();
        check("t6_bit_ready", int'(bit_ready), 0);
        chip_strobe_in = 1'b1;
        step();
        chip_strobe_in = 1'b0;
        step();
        bit_valid = 1'b0;
        repeat (2) step();
        strobes(10);
        strobes(11);
        push_lit(LIT0);
        push_lit(LIT1);
        check_chips("t6");
        check("t6_symbol_done", sd_cnt, 2);
        check("t6_underrun", ur_cnt, 0);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
